// File: rtl/i2c_cpu_bridge.sv
// CPU-side front end for an I2C master: TX/RX byte FIFOs, latched transfer setup
// registers, and a small sequencer driving one transfer through a start/ack handshake.
module i2c_cpu_bridge #(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8,
  parameter int DATA_W   = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RESET,
  input  logic                      ABORT,
  input  logic                      TX_IE,
  input  logic                      RX_IE,
  input  logic                      INT_CLR,
  input  logic                      START,
  input  logic                      ADR_MOD,
  input  logic                      RW_MOD,
  input  logic [1:0]                BPS,
  input  logic [9:0]                slave_addr,
  input  logic [7:0]                num_bytes,
  input  logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_wr,
  input  logic                      rx_rd,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      tx_full,
  output logic                      rx_empty,
  output logic [$clog2(TX_DEPTH):0] tx_level,
  output logic [$clog2(RX_DEPTH):0] rx_level,
  output logic                      busy,
  output logic                      err_underrun,
  output logic                      err_overflow,
  output logic                      err_len,
  output logic [9:0]                slave_addr_reg,
  output logic [7:0]                byte_cnt_reg,
  output logic [DATA_W-1:0]         transmit_data,
  output logic [5:0]                config_reg,
  output logic [7:0]                mode_reg,
  input  logic                      start_ack,
  input  logic                      transmit_data_requested,
  input  logic                      received_data_valid,
  input  logic [DATA_W-1:0]         received_data
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [TX_AW:0]   TX_FULL_LVL = (TX_AW + 1)'(TX_DEPTH);
  localparam logic [RX_AW:0]   RX_FULL_LVL = (RX_AW + 1)'(RX_DEPTH);
  localparam logic [TX_AW:0]   TX_CNT_ONE  = (TX_AW + 1)'(1);
  localparam logic [RX_AW:0]   RX_CNT_ONE  = (RX_AW + 1)'(1);
  localparam logic [TX_AW-1:0] TX_PTR_ONE  = TX_AW'(1);
  localparam logic [RX_AW-1:0] RX_PTR_ONE  = RX_AW'(1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_ACK = 2'd1;
  localparam logic [1:0] XFER     = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  logic [1:0]        state_r, state_nx_s;
  logic [7:0]        xfer_cnt_r;
  logic [DATA_W-1:0] tx_mem_r [TX_DEPTH];
  logic [DATA_W-1:0] rx_mem_r [RX_DEPTH];
  logic [TX_AW-1:0]  tx_wp_r, tx_rp_r;
  logic [RX_AW-1:0]  rx_wp_r, rx_rp_r;
  logic [TX_AW:0]    tx_cnt_r;
  logic [RX_AW:0]    rx_cnt_r;
  logic              err_un_r, err_ov_r, err_len_r;
  logic              go_r, abort_p_r, cfg_reset_r, cfg_txie_r, cfg_rxie_r, cfg_intclr_r;
  logic [9:0]        addr_r;
  logic [7:0]        nbytes_r, mode_r;
  logic [DATA_W-1:0] tdata_r;

  logic abort_s, ack_s, start_ok_s, len_err_s, xfer_ok_s, wr_mode_s;
  logic byte_req_s, byte_val_s, byte_done_s, last_byte_s;
  logic tx_push_s, tx_pop_s, underrun_s, rx_push_s, rx_pop_s, overflow_s;
  logic tx_empty_s, rx_full_s;

  assign tx_empty_s = (tx_cnt_r == '0);
  assign rx_full_s  = (rx_cnt_r == RX_FULL_LVL);
  assign wr_mode_s  = ~mode_r[0];

  // ABORT and RESET pre-empt any handshake or strobe arriving in the same cycle.
  assign abort_s     = ABORT & ~RESET & ((state_r == WAIT_ACK) | (state_r == XFER));
  assign ack_s       = start_ack & ~RESET & ~ABORT & (state_r == WAIT_ACK);
  assign start_ok_s  = START & ~RESET & (state_r == IDLE) & (num_bytes != 8'd0);
  assign len_err_s   = START & ~RESET & (state_r == IDLE) & (num_bytes == 8'd0);
  assign xfer_ok_s   = ~RESET & ~ABORT & (state_r == XFER);
  assign byte_req_s  = xfer_ok_s & wr_mode_s & transmit_data_requested;
  assign byte_val_s  = xfer_ok_s & ~wr_mode_s & received_data_valid;
  assign byte_done_s = byte_req_s | byte_val_s;
  assign last_byte_s = byte_done_s & ((xfer_cnt_r + 8'd1) == nbytes_r);

  assign tx_pop_s   = byte_req_s & ~tx_empty_s;
  assign underrun_s = byte_req_s & tx_empty_s;
  assign tx_push_s  = tx_wr & ~RESET & (~tx_full | tx_pop_s);
  assign rx_pop_s   = rx_rd & ~RESET & ~rx_empty;
  assign rx_push_s  = byte_val_s & (~rx_full_s | rx_pop_s);
  assign overflow_s = byte_val_s & rx_full_s & ~rx_pop_s;

  assign tx_full        = (tx_cnt_r == TX_FULL_LVL);
  assign rx_empty       = (rx_cnt_r == '0);
  assign tx_level       = tx_cnt_r;
  assign rx_level       = rx_cnt_r;
  assign rx_data        = rx_empty ? '0 : rx_mem_r[rx_rp_r];
  assign busy           = (state_r != IDLE);
  assign err_underrun   = err_un_r;
  assign err_overflow   = err_ov_r;
  assign err_len        = err_len_r;
  assign slave_addr_reg = addr_r;
  assign byte_cnt_reg   = nbytes_r;
  assign transmit_data  = tdata_r;
  assign mode_reg       = mode_r;
  assign config_reg     = {cfg_reset_r, abort_p_r, cfg_txie_r, cfg_rxie_r, cfg_intclr_r, go_r};

  // Sequencer next-state decode.
  always_comb begin
    state_nx_s = state_r;
    if (RESET) begin
      state_nx_s = IDLE;
    end else begin
      case (state_r)
        IDLE:     if (start_ok_s) state_nx_s = WAIT_ACK; else state_nx_s = IDLE;
        WAIT_ACK: if (ABORT) state_nx_s = IDLE; else if (ack_s) state_nx_s = XFER; else state_nx_s = WAIT_ACK;
        XFER:     if (ABORT) state_nx_s = IDLE; else if (last_byte_s) state_nx_s = DONE; else state_nx_s = XFER;
        DONE:     state_nx_s = IDLE;
        default:  state_nx_s = IDLE;
      endcase
    end
  end

  // Sequencer state, byte counter, setup registers and config flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r      <= IDLE;
      xfer_cnt_r   <= 8'd0;
      go_r         <= 1'b0;
      abort_p_r    <= 1'b0;
      cfg_reset_r  <= 1'b0;
      cfg_txie_r   <= 1'b0;
      cfg_rxie_r   <= 1'b0;
      cfg_intclr_r <= 1'b0;
      addr_r       <= 10'd0;
      nbytes_r     <= 8'd0;
      mode_r       <= 8'd0;
      tdata_r      <= '0;
    end else begin
      state_r      <= state_nx_s;
      abort_p_r    <= abort_s;
      cfg_reset_r  <= RESET;
      cfg_txie_r   <= TX_IE;
      cfg_rxie_r   <= RX_IE;
      cfg_intclr_r <= INT_CLR;
      if (RESET || abort_s || ack_s) go_r <= 1'b0;
      else if (start_ok_s)           go_r <= 1'b1;
      if (start_ok_s) begin
        addr_r   <= slave_addr;
        nbytes_r <= num_bytes;
        mode_r   <= {4'b0000, BPS, ADR_MOD, RW_MOD};
      end
      if (ack_s)            xfer_cnt_r <= 8'd0;
      else if (byte_done_s) xfer_cnt_r <= xfer_cnt_r + 8'd1;
      if (tx_pop_s)        tdata_r <= tx_mem_r[tx_rp_r];
      else if (underrun_s) tdata_r <= '0;
    end
  end

  // Sticky error flags; a same-cycle set beats INT_CLR.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_un_r  <= 1'b0;
      err_ov_r  <= 1'b0;
      err_len_r <= 1'b0;
    end else begin
      err_un_r  <= underrun_s | (err_un_r  & ~INT_CLR);
      err_ov_r  <= overflow_s | (err_ov_r  & ~INT_CLR);
      err_len_r <= len_err_s  | (err_len_r & ~INT_CLR);
    end
  end

  // TX FIFO pointers and occupancy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_wp_r  <= '0;
      tx_rp_r  <= '0;
      tx_cnt_r <= '0;
    end else if (RESET) begin
      tx_wp_r  <= '0;
      tx_rp_r  <= '0;
      tx_cnt_r <= '0;
    end else begin
      if (tx_push_s) tx_wp_r <= tx_wp_r + TX_PTR_ONE;
      if (tx_pop_s)  tx_rp_r <= tx_rp_r + TX_PTR_ONE;
      if (tx_push_s && !tx_pop_s)      tx_cnt_r <= tx_cnt_r + TX_CNT_ONE;
      else if (!tx_push_s && tx_pop_s) tx_cnt_r <= tx_cnt_r - TX_CNT_ONE;
    end
  end

  // RX FIFO pointers and occupancy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_wp_r  <= '0;
      rx_rp_r  <= '0;
      rx_cnt_r <= '0;
    end else if (RESET) begin
      rx_wp_r  <= '0;
      rx_rp_r  <= '0;
      rx_cnt_r <= '0;
    end else begin
      if (rx_push_s) rx_wp_r <= rx_wp_r + RX_PTR_ONE;
      if (rx_pop_s)  rx_rp_r <= rx_rp_r + RX_PTR_ONE;
      if (rx_push_s && !rx_pop_s)      rx_cnt_r <= rx_cnt_r + RX_CNT_ONE;
      else if (!rx_push_s && rx_pop_s) rx_cnt_r <= rx_cnt_r - RX_CNT_ONE;
    end
  end

  // FIFO storage; contents are only meaningful behind the pointers.
  always_ff @(posedge CLK) begin
    if (tx_push_s) tx_mem_r[tx_wp_r] <= tx_data;
    if (rx_push_s) rx_mem_r[rx_wp_r] <= received_data;
  end

endmodule

// File: doc/i2c_cpu_bridge.md
I2C_CPU_BRIDGE -- requirements
Module: i2c_cpu_bridge

Interface
REQ-001 Parameter TX_DEPTH, default 8, TX FIFO entries; power of two, range 2..256.
REQ-002 Parameter RX_DEPTH, default 8, RX FIFO entries; power of two, range 2..256.
REQ-003 Parameter DATA_W, default 8, data byte width; only 8 is legal.
REQ-004 Reset is asynchronous and active-high; the block has one clock.
REQ-005 CLK  in  1  single clock, rising edge.
REQ-006 RST  in  1  asynchronous reset, active-high.
REQ-007 RESET, ABORT, TX_IE, RX_IE, INT_CLR, START, ADR_MOD, RW_MOD  in  1 each  CPU control; START and ABORT are one-cycle pulses.
REQ-008 BPS  in  2  bus rate select; slave_addr  in  10; num_bytes  in  8.
REQ-009 tx_data  in  8, with tx_wr  in  1: CPU push into the TX FIFO.
REQ-010 rx_rd  in  1  CPU pop; rx_data  out  8  RX FIFO head, valid while rx_empty=0.
REQ-011 tx_full, rx_empty  out  1; tx_level, rx_level  out  clog2(DEPTH)+1  FIFO occupancy.
REQ-012 busy  out  1; err_underrun, err_overflow, err_len  out  1 each, sticky.
REQ-013 slave_addr_reg  out  10; byte_cnt_reg  out  8; transmit_data  out  8; config_reg  out  6; mode_reg  out  8  (to master).
REQ-014 start_ack, transmit_data_requested, received_data_valid  in  1; received_data  in  8 (from master).

Function
REQ-015 config_reg SHALL be {RESET, ABORT_p, TX_IE, RX_IE, INT_CLR, go}, where ABORT_p is the registered one-cycle abort pulse.
REQ-016 mode_reg SHALL be {4'b0000, BPS, ADR_MOD, RW_MOD}; RW_MOD=1 means read.
REQ-017 The FSM SHALL have states IDLE, WAIT_ACK, XFER and DONE; busy=1 in every state except IDLE.
REQ-018 IDLE: START with num_bytes!=0 SHALL latch slave_addr, num_bytes and mode into the output registers next cycle, set go=1, and move to WAIT_ACK.
REQ-019 IDLE: START with num_bytes==0 SHALL set err_len and stay in IDLE; START outside IDLE SHALL be ignored.
REQ-020 WAIT_ACK: start_ack SHALL clear go the next cycle, zero the transfer counter, and move to XFER.
REQ-021 XFER write: transmit_data_requested SHALL pop the TX FIFO and drive transmit_data in the following cycle; transmit_data holds until the next pop.
REQ-022 XFER write with TX FIFO empty: transmit_data SHALL be 8'h00, err_underrun SHALL set, and the byte still counts.
REQ-023 XFER read: received_data_valid SHALL push received_data into the RX FIFO.
REQ-024 XFER read with RX FIFO full and no same-cycle rx_rd: the byte SHALL be dropped, err_overflow SHALL set, and the byte still counts.
REQ-025 Counter reaching byte_cnt_reg SHALL move XFER to DONE; DONE SHALL last one cycle, then return to IDLE.
REQ-026 Request and valid strobes SHALL be ignored outside XFER and in read/write mode mismatch.
REQ-027 ABORT in WAIT_ACK or XFER SHALL drive ABORT_p=1 for one cycle, clear go, and return to IDLE the next cycle; FIFO contents SHALL be kept.
REQ-028 Both FIFOs SHALL be circular with wrap-around pointers.
REQ-029 Push when full SHALL be accepted only with a simultaneous pop; pop when empty SHALL be ignored.
REQ-030 Simultaneous push and pop SHALL leave the level unchanged.
REQ-031 INT_CLR SHALL clear err_underrun, err_overflow and err_len; a same-cycle set wins.
REQ-032 RESET=1 SHALL flush both FIFOs and force IDLE synchronously, and SHALL be passed through in config_reg.

Reset
REQ-033 While RST=1, all outputs SHALL be 0 except rx_empty=1, and the state SHALL be IDLE.
REQ-034 RST asserted mid-transfer SHALL abandon the transfer immediately, with no ABORT_p pulse.
REQ-035 After RST deasserts, the first accepted START SHALL behave per REQ-018.

Verification
REQ-036 Push 3 bytes A1,B2,C3; START with RW_MOD=0, num_bytes=3; start_ack; 3 requests -> transmit_data A1,B2,C3, each one cycle after its request; DONE; busy falls; tx_level=0.
REQ-037 Read with num_bytes=2; two valids carrying 5A,6B -> rx_level=2; rx_rd twice returns 5A then 6B; rx_empty=1.
REQ-038 Write with num_bytes=2 and 1 byte queued -> second transmit_data=00, err_underrun=1; INT_CLR -> err_underrun=0.
REQ-039 RX_DEPTH=2, read of 3 bytes with no rx_rd -> third byte dropped, err_overflow=1, rx_level=2; simultaneous push and pop at full -> level stays 2.
REQ-040 ABORT during XFER -> config_reg[4] high exactly one cycle, IDLE next cycle; START with num_bytes=0 -> err_len=1, go stays 0.
